count_match_capture: RTL and testbench

COUNT_MATCH_CAPTURE -- requirements
Module: count_match_capture

---
 rtl/count_pkg.sv | 13 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/count_match_capture.sv | 99 +++++++++
 tb/tb_count_match_capture.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared definitions for the count/match/capture block.
// Provides the FSM state encoding and the default datapath width.
package count_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO for captured counts.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset (empties FIFO, zeroes storage)
//   push       write request; push_data is stored if space (or a same-cycle pop) allows
//   push_data  value to store
//   pop_ready  consumer accepts data; ignored while empty
//   data       entry at the head (0 after reset until the first push)
//   valid      FIFO not empty
//   drop       push refused because the FIFO was full with no pop this cycle
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             pop;
    logic             write;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && pop_ready;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign write = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign data  = mem[rd_ptr[AW-1:0]];
    assign valid = !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (write) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_match_capture.sv
// Compares a running count against an armed target and captures matching
// counts into a small FIFO. One-shot mode stops after the first match;
// periodic mode advances the target by 'period' after each match.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   count_in/_valid   running count and its qualifier
//   cmp_val, period   first target and periodic increment (sampled on arm)
//   mode              0 = one-shot, 1 = periodic (sampled on arm)
//   arm               single-cycle arm/re-arm request, wins over a match
//   match_pulse       registered one-cycle pulse per match
//   out_data/valid    FIFO head and non-empty flag; out_ready pops
//   overflow          sticky: a capture was dropped (cleared by arm)
//   armed             FSM is in ARMED
module count_match_capture
    import count_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_in_valid,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic [WIDTH-1:0] period,
    input  logic             mode,
    input  logic             arm,
    output logic             match_pulse,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             armed
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] target_next;
    logic [WIDTH-1:0] period_q;
    logic             mode_q;
    logic             match;
    logic             drop;

    assign match = (state == ARMED) && count_in_valid && (count_in == target) && !arm;
    assign armed = (state == ARMED);

    always_comb begin
        state_next  = state;
        target_next = target;
        if (arm) begin
            state_next  = ARMED;
            target_next = cmp_val;
        end else if (match) begin
            if (mode_q) begin
                target_next = target + period_q;
            end else begin
                state_next = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            target      <= '0;
            mode_q      <= 1'b0;
            period_q    <= '0;
            match_pulse <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_next;
            target      <= target_next;
            match_pulse <= match;
            if (arm) begin
                mode_q   <= mode;
                period_q <= period;
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (match),
        .push_data (count_in),
        .pop_ready (out_ready),
        .data      (out_data),
        .valid     (out_valid),
        .drop      (drop)
    );

endmodule

// File: tb/tb_count_match_capture.sv
module tb_count_match_capture;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] count_in;
    logic             count_in_valid;
    logic [WIDTH-1:0] cmp_val;
    logic [WIDTH-1:0] period;
    logic             mode;
    logic             arm;
    logic             match_pulse;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;
    logic             armed;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: captures held as a queue, behaviour from the rules.
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];
    logic [WIDTH-1:0] m_target;
    logic [WIDTH-1:0] m_period;
    bit               m_periodic;
    int               m_state;   // 0 idle, 1 armed, 2 done
    bit               m_pulse;
    bit               m_ovf;

    always #5 clk = ~clk;

    count_match_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .count_in       (count_in),
        .count_in_valid (count_in_valid),
        .cmp_val        (cmp_val),
        .period         (period),
        .mode           (mode),
        .arm            (arm),
        .match_pulse    (match_pulse),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow       (overflow),
        .armed          (armed)
    );

    // Advance one clock: update the model from current inputs, record any
    // consumer pop seen on the bus, then sample point is 1ns after the edge.
    task automatic tick();
        bit m;
        if (rst && out_valid && out_ready) got_q.push_back(out_data);
        if (!rst) begin
            exp_q.delete();
            m_target = '0; m_period = '0; m_periodic = 0;
            m_state = 0; m_pulse = 0; m_ovf = 0;
        end else begin
            m = (m_state == 1) && count_in_valid && (count_in == m_target) && !arm;
            if (arm) begin
                m_target = cmp_val; m_period = period; m_periodic = mode;
                m_ovf = 0; m_state = 1;
            end else if (m) begin
                if (m_periodic) m_target = m_target + m_period;
                else m_state = 2;
            end
            if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (m) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(count_in);
                else m_ovf = 1;
            end
            m_pulse = m;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arm = 0; count_in_valid = 0; count_in = '0; out_ready = 0;
        cmp_val = '0; period = '0; mode = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 0;
        tick(); tick();
        rst = 1;
        got_q.delete();
    endtask

    task automatic arm_with(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] p, input logic md);
        cmp_val = c; period = p; mode = md; arm = 1;
        tick();
        arm = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        tests_run++;
        if (match_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_match_pulse got %0b want 0", match_pulse); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        tests_run++;
        if (armed !== 1'b0) begin tests_failed++; $display("FAIL reset_armed got %0b want 0", armed); end
        tests_run++;
        if (out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data got %h want 0", out_data); end
    endtask

    task automatic test_one_shot();
        int pulses = 0;
        reset_dut();
        arm_with(32'd5, 32'd0, 1'b0);
        tests_run++;
        if (armed !== 1'b1) begin tests_failed++; $display("FAIL oneshot_armed got %0b want 1", armed); end
        for (int c = 0; c <= 10; c++) begin
            count_in = c; count_in_valid = 1;
            tick();
            if (match_pulse === 1'b1) begin
                pulses++;
                tests_run++;
                if (c != 5) begin tests_failed++; $display("FAIL oneshot_pulse_cycle got count %0d want 5", c); end
            end
        end
        count_in_valid = 0;
        tests_run++;
        if (pulses != 1) begin tests_failed++; $display("FAIL oneshot_pulse_count got %0d want 1", pulses); end
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'd5) begin
            tests_failed++; $display("FAIL oneshot_capture got v=%0b d=%0d want v=1 d=5", out_valid, out_data);
        end
        tests_run++;
        if (armed !== 1'b0) begin tests_failed++; $display("FAIL oneshot_done got armed=%0b want 0", armed); end
    endtask

    task automatic test_periodic();
        logic [WIDTH-1:0] want[4] = '{32'd3, 32'd7, 32'd11, 32'd15};
        int pulses = 0;
        reset_dut();
        out_ready = 1;
        arm_with(32'd3, 32'd4, 1'b1);
        for (int c = 0; c <= 15; c++) begin
            count_in = c; count_in_valid = 1;
            tick();
            if (match_pulse === 1'b1) pulses++;
        end
        count_in_valid = 0;
        repeat (3) tick();
        tests_run++;
        if (pulses != 4) begin tests_failed++; $display("FAIL periodic_pulses got %0d want 4", pulses); end
        tests_run++;
        if (got_q.size() != 4) begin tests_failed++; $display("FAIL periodic_count got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== want[i]) begin tests_failed++; $display("FAIL periodic_data[%0d] got %0d want %0d", i, got_q[i], want[i]); end
        end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL periodic_overflow got %0b want 0", overflow); end
    endtask

    task automatic test_overflow();
        reset_dut();
        arm_with(32'd10, 32'd1, 1'b1);
        for (int c = 10; c <= 15; c++) begin
            count_in = c; count_in_valid = 1;
            tick();
        end
        count_in_valid = 0;
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 32'(10 + k)) begin
                tests_failed++; $display("FAIL ovf_drain[%0d] got v=%0b d=%0d want v=1 d=%0d", k, out_valid, out_data, 10 + k);
            end
            tick();
        end
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_empty got %0b want 0", out_valid); end
        out_ready = 0;
        arm_with(32'd100, 32'd1, 1'b1);
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_rearm_clear got %0b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        arm_with(32'd0, 32'd1, 1'b1);
        for (int c = 0; c <= 3; c++) begin
            count_in = c; count_in_valid = 1; tick();
        end
        out_ready = 1;
        for (int c = 4; c <= 7; c++) begin
            count_in = c; count_in_valid = 1; tick();
        end
        count_in_valid = 0;
        repeat (5) tick();
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL b2b_overflow got %0b want 0", overflow); end
        tests_run++;
        if (got_q.size() != 8) begin tests_failed++; $display("FAIL b2b_count got %0d want 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== 32'(i)) begin tests_failed++; $display("FAIL b2b_data[%0d] got %0d want %0d", i, got_q[i], i); end
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] c;
        reset_dut();
        out_ready = 1;
        arm_with(32'hFFFF_FFFE, 32'd3, 1'b1);
        c = 32'hFFFF_FFFC;
        for (int i = 0; i < 8; i++) begin
            count_in = c; count_in_valid = 1; tick();
            c = c + 1'b1;
        end
        count_in_valid = 0;
        repeat (3) tick();
        tests_run++;
        if (got_q.size() != 2) begin tests_failed++; $display("FAIL wrap_count got %0d want 2", got_q.size()); end
        else begin
            tests_run++;
            if (got_q[0] !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL wrap_first got %h want fffffffe", got_q[0]); end
            tests_run++;
            if (got_q[1] !== 32'h0000_0001) begin tests_failed++; $display("FAIL wrap_second got %h want 00000001", got_q[1]); end
        end
    endtask

    task automatic test_priority();
        reset_dut();
        arm_with(32'd7, 32'd0, 1'b0);
        count_in = 32'd7; count_in_valid = 1;
        cmp_val = 32'd20; arm = 1;
        tick();
        arm = 0;
        tests_run++;
        if (match_pulse !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL prio_arm_wins got pulse=%0b v=%0b want 0 0", match_pulse, out_valid);
        end
        tick();
        tests_run++;
        if (match_pulse !== 1'b0) begin tests_failed++; $display("FAIL prio_old_target got pulse=%0b want 0", match_pulse); end
        count_in = 32'd20;
        tick();
        tests_run++;
        if (match_pulse !== 1'b1) begin tests_failed++; $display("FAIL prio_new_target got pulse=%0b want 1", match_pulse); end

        reset_dut();
        arm_with(32'd1, 32'd1, 1'b1);
        count_in = 32'd1; count_in_valid = 1; tick();
        count_in = 32'd2; tick();
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL prio_queued got v=%0b want 1", out_valid); end
        count_in = 32'd3; out_ready = 1; rst = 0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || armed !== 1'b0 || match_pulse !== 1'b0) begin
            tests_failed++; $display("FAIL prio_reset got v=%0b armed=%0b pulse=%0b want 0 0 0", out_valid, armed, match_pulse);
        end
        rst = 1;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] cnt;
        reset_dut();
        cnt = '0;
        for (int n = 0; n < 400; n++) begin
            arm = ($urandom_range(0, 15) == 0);
            cmp_val = cnt + $urandom_range(0, 6);
            period = $urandom_range(0, 3);
            mode = $urandom_range(0, 1);
            count_in_valid = $urandom_range(0, 3) != 0;
            if (count_in_valid && $urandom_range(0, 3) != 0) cnt = cnt + 1'b1;
            count_in = cnt;
            out_ready = $urandom_range(0, 2) == 0;
            rst = ($urandom_range(0, 79) != 0);
            tick();
            tests_run++;
            if (match_pulse !== m_pulse) begin tests_failed++; $display("FAIL rnd_pulse@%0d got %0b want %0b", n, match_pulse, m_pulse); end
            tests_run++;
            if (out_valid !== (exp_q.size() > 0)) begin tests_failed++; $display("FAIL rnd_valid@%0d got %0b want %0b", n, out_valid, exp_q.size() > 0); end
            tests_run++;
            if (overflow !== m_ovf) begin tests_failed++; $display("FAIL rnd_ovf@%0d got %0b want %0b", n, overflow, m_ovf); end
            tests_run++;
            if (armed !== (m_state == 1)) begin tests_failed++; $display("FAIL rnd_armed@%0d got %0b want %0b", n, armed, m_state == 1); end
            if (exp_q.size() > 0) begin
                tests_run++;
                if (out_data !== exp_q[0]) begin tests_failed++; $display("FAIL rnd_data@%0d got %h want %h", n, out_data, exp_q[0]); end
            end
        end
        rst = 1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        exp_q.delete(); got_q.delete();
        m_target = '0; m_period = '0; m_periodic = 0; m_state = 0; m_pulse = 0; m_ovf = 0;
        test_reset();
        test_one_shot();
        test_periodic();
        test_overflow();
        test_back_to_back();
        test_wrap();
        test_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
